// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - round-robin arbiter sharing one memory port between instr fetch and data ports
// Optional statistics counters enabled with CORE_MEM_ARB_STATS_EN.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef CORE_MEM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_instr_grants_o,
  output logic [31:0]             stat_data_grants_o,
  output logic [31:0]             stat_conflicts_o
`endif
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e           state_q, state_d;
  logic             rr_data_q;  // 1: data wins the next tie
  logic             sel_data, sel_req;
  logic             fifo_full, fifo_empty, push, pop, head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ids_q [MAX_OUTSTANDING];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = ids_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    sel_data    = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      LOCK_I:  sel_data = 1'b0;
      LOCK_D:  sel_data = 1'b1;
      default: sel_data = (instr_req_i && data_req_i) ? rr_data_q : data_req_i;
    endcase
    sel_req   = sel_data ? data_req_i : instr_req_i;
    mem_req_o = rst_ni && sel_req && !fifo_full;
    // A stalled grant freezes the selection; a full FIFO leaves the state alone.
    if (mem_req_o) state_d = mem_gnt_i ? IDLE : (sel_data ? LOCK_D : LOCK_I);
    if (rst_ni) begin
      if (sel_data) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = {BE_W{1'b1}};
      end
    end
  end

  assign push           = mem_req_o && mem_gnt_i;
  assign pop            = mem_rvalid_i && !fifo_empty;
  assign instr_gnt_o    = push && !sel_data;
  assign data_gnt_o     = push && sel_data;
  assign instr_rvalid_o = pop && !head;
  assign data_rvalid_o  = pop && head;
  assign instr_rdata_o  = rst_ni ? mem_rdata_i : '0;
  assign data_rdata_o   = rst_ni ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_data_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q  <= ptr_inc(wr_ptr_q);
        rr_data_q <= !sel_data;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) ids_q[wr_ptr_q] <= sel_data;
  end

`ifdef CORE_MEM_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_instr_grants_o <= '0;
      stat_data_grants_o  <= '0;
      stat_conflicts_o    <= '0;
    end else begin
      if (instr_gnt_o) stat_instr_grants_o <= stat_instr_grants_o + 32'd1;
      if (data_gnt_o)  stat_data_grants_o  <= stat_data_grants_o + 32'd1;
      if (instr_req_i && data_req_i && (instr_gnt_o ^ data_gnt_o))
        stat_conflicts_o <= stat_conflicts_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed and randomized bench for core_mem_arbiter with a queue-based reference model
module tb_core_mem_arbiter;
  localparam int AW = 64, DW = 64, BW = 8, MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          instr_req, data_req, data_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] instr_addr, data_addr;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata, mem_rdata;
  logic          instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic          mem_req_o, mem_we_o;
  logic [DW-1:0] instr_rdata_o, data_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
`ifdef CORE_MEM_ARB_STATS_EN
  logic [31:0]   stat_i_o, stat_d_o, stat_c_o;
`endif

  core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we), .data_be_i(data_be),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
`ifdef CORE_MEM_ARB_STATS_EN
    , .stat_instr_grants_o(stat_i_o), .stat_data_grants_o(stat_d_o), .stat_conflicts_o(stat_c_o)
`endif
  );

  int n_cmp = 0, n_err = 0;
  // Reference model: in-order queue of issuing ports, a stalled-port lock and the tie preference.
  int mq[$];
  int lock_port = -1;
  bit pref_data = 1'b1;
  int st_i = 0, st_d = 0, st_c = 0;
  // Samples of the DUT taken by the last cycle, for directed checks against constants.
  logic s_igt, s_dgt, s_irv, s_drv, s_mreq, s_mwe;
  logic [BW-1:0] s_mbe;
  logic [DW-1:0] s_irdata;
  int dut_g[$], dut_r[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with inputs set; checks at the falling edge and returns at next posedge+1.
  task automatic cycle();
    int sel;
    bit full, ereq, eig, edg, eir, edr;
    #4;
    full = (mq.size() == MAXO);
    if (lock_port >= 0)             sel = lock_port;
    else if (instr_req && data_req) sel = pref_data ? 1 : 0;
    else if (data_req)              sel = 1;
    else if (instr_req)             sel = 0;
    else                            sel = -1;
    ereq = (sel >= 0) && !full;
    eig  = ereq && mem_gnt && (sel == 0);
    edg  = ereq && mem_gnt && (sel == 1);
    eir  = mem_rvalid && (mq.size() > 0) && (mq[0] == 0);
    edr  = mem_rvalid && (mq.size() > 0) && (mq[0] == 1);
    chk("mem_req", mem_req_o, ereq);
    chk("instr_gnt", instr_gnt_o, eig);
    chk("data_gnt", data_gnt_o, edg);
    chk("instr_rvalid", instr_rvalid_o, eir);
    chk("data_rvalid", data_rvalid_o, edr);
    if (ereq) begin
      chk("mem_addr", mem_addr_o, (sel == 1) ? data_addr : instr_addr);
      chk("mem_we", mem_we_o, (sel == 1) ? data_we : 1'b0);
      chk("mem_be", mem_be_o, (sel == 1) ? data_be : 8'hFF);
      chk("mem_wdata", mem_wdata_o, (sel == 1) ? data_wdata : 64'd0);
    end
    if (eir) chk("instr_rdata", instr_rdata_o, mem_rdata);
    if (edr) chk("data_rdata", data_rdata_o, mem_rdata);
    s_igt = instr_gnt_o; s_dgt = data_gnt_o; s_irv = instr_rvalid_o; s_drv = data_rvalid_o;
    s_mreq = mem_req_o; s_mwe = mem_we_o; s_mbe = mem_be_o; s_irdata = instr_rdata_o;
    if (s_igt) dut_g.push_back(0);
    if (s_dgt) dut_g.push_back(1);
    if (s_irv) dut_r.push_back(0);
    if (s_drv) dut_r.push_back(1);
    if (instr_req && data_req && (eig != edg)) st_c++;
    if (mem_rvalid && mq.size() > 0) void'(mq.pop_front());
    if (ereq) begin
      if (mem_gnt) begin
        mq.push_back(sel);
        pref_data = (sel == 0);
        lock_port = -1;
        if (sel == 0) st_i++; else st_d++;
      end else lock_port = sel;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; data_we = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  task automatic drain();
    idle_inputs();
    mem_rvalid = 1;
    for (int k = 0; k < 8 && mq.size() > 0; k++) cycle();
    mem_rvalid = 0;
  endtask

  initial begin
    rst_n = 0; idle_inputs();
    instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
    instr_addr = 64'h40; data_addr = 64'h80; data_be = 8'hFF; data_wdata = 64'h1234; mem_rdata = 64'h55AA;
    #12;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rdata", instr_rdata_o | data_rdata_o, 0);
    @(posedge clk); #1;
    idle_inputs(); rst_n = 1;

    // single fetch, response next cycle
    instr_req = 1; instr_addr = 64'h8000_0000; mem_gnt = 1;
    cycle();
    chk("t1_igt", s_igt, 1); chk("t1_dgt", s_dgt, 0);
    instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    cycle();
    chk("t1_irv", s_irv, 1); chk("t1_irdata", s_irdata, 64'hDEAD_BEEF_0000_0001); chk("t1_drv", s_drv, 0);
    drain();

    // both requesting every cycle: alternate starting with data
    dut_g.delete(); dut_r.delete();
    instr_req = 1; data_req = 1; mem_gnt = 1; data_we = 0; instr_addr = 64'h100; data_addr = 64'h200;
    cycle();
    mem_rvalid = 1;
    repeat (3) cycle();
    drain();
    chk("t2_ngrant", dut_g.size(), 4);
    chk("t2_nresp", dut_r.size(), 4);
    for (int k = 0; k < 4 && k < dut_g.size() && k < dut_r.size(); k++) begin
      chk("t2_grant_order", dut_g[k], (k % 2 == 0) ? 1 : 0);
      chk("t2_resp_order", dut_r[k], (k % 2 == 0) ? 1 : 0);
    end

    // stalled data write locks out a later fetch
    data_req = 1; data_we = 1; data_be = 8'h0F; data_wdata = 64'h1122334455667788; data_addr = 64'h3000;
    mem_gnt = 0;
    cycle(); chk("t3_we_c1", s_mwe, 1); chk("t3_be_c1", s_mbe, 8'h0F); chk("t3_dgt_c1", s_dgt, 0);
    instr_req = 1; instr_addr = 64'h4000;
    cycle(); chk("t3_igt_c2", s_igt, 0); chk("t3_we_c2", s_mwe, 1);
    cycle(); chk("t3_igt_c3", s_igt, 0); chk("t3_be_c3", s_mbe, 8'h0F);
    mem_gnt = 1;
    cycle(); chk("t3_dgt_c4", s_dgt, 1); chk("t3_igt_c4", s_igt, 0);
    data_req = 0; data_we = 0;
    cycle(); chk("t3_igt_c5", s_igt, 1);
    drain();

    // full FIFO blocks, pop cycle does not push through
    instr_req = 1; mem_gnt = 1;
    cycle(); cycle();
    cycle(); chk("t4_full_req", s_mreq, 0); chk("t4_full_igt", s_igt, 0);
    mem_rvalid = 1;
    cycle(); chk("t4_pop_req", s_mreq, 0); chk("t4_pop_irv", s_irv, 1);
    mem_rvalid = 0;
    cycle(); chk("t4_after_pop_igt", s_igt, 1);
    drain();

    // stray response with empty FIFO
    mem_rvalid = 1; mem_rdata = 64'hBAD;
    cycle(); chk("t5_irv", s_irv, 0); chk("t5_drv", s_drv, 0);
    mem_rvalid = 0;

    // reset with two outstanding
    data_req = 1; mem_gnt = 1;
    cycle(); cycle();
    instr_req = 1; mem_rvalid = 1; mem_rdata = 64'hFFFF;
    rst_n = 0; #2;
    chk("t6_mem_req", mem_req_o, 0);
    chk("t6_gnts", {instr_gnt_o, data_gnt_o}, 0);
    chk("t6_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
    chk("t6_mem_be", mem_be_o, 0);
    chk("t6_mem_wdata", mem_wdata_o | mem_addr_o, 0);
    mq.delete(); lock_port = -1; pref_data = 1; st_i = 0; st_d = 0; st_c = 0;
    @(posedge clk); #1;
    idle_inputs(); rst_n = 1;
    mem_rvalid = 1;
    cycle(); chk("t6_late_rv1", {s_irv, s_drv}, 0);
    cycle(); chk("t6_late_rv2", {s_irv, s_drv}, 0);
    mem_rvalid = 0;

`ifdef CORE_MEM_ARB_STATS_EN
    instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
    repeat (10) cycle();
    drain();
    chk("t7_stat_i", stat_i_o, 5); chk("t7_stat_d", stat_d_o, 5); chk("t7_stat_c", stat_c_o, 10);
`endif

    // randomized traffic
    idle_inputs(); s_igt = 0; s_dgt = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!(instr_req && !s_igt)) begin
        instr_req  = ($urandom_range(0, 2) != 0);
        instr_addr = {$urandom, $urandom};
      end
      if (!(data_req && !s_dgt)) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_addr  = {$urandom, $urandom};
        data_we    = $urandom_range(0, 1);
        data_be    = BW'($urandom);
        data_wdata = {$urandom, $urandom};
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (mq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      mem_rdata  = {$urandom, $urandom};
      cycle();
    end
`ifdef CORE_MEM_ARB_STATS_EN
    chk("rand_stat_i", stat_i_o, 32'(st_i));
    chk("rand_stat_d", stat_d_o, 32'(st_d));
    chk("rand_stat_c", stat_c_o, 32'(st_c));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-port memory/cache interface between the core's instruction-fetch port (read-only) and data port (read/write).
- All three sides use the core req/gnt/rvalid protocol.
- Performs round-robin arbitration and holds the selection while the memory stalls a grant.
- Tracks outstanding transactions in order, so each rvalid/rdata is routed back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 64, address width of all ports.
- DATA_WIDTH, 64, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the in-order response-ID FIFO; must be a power of two, ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch read data valid
- instr_rdata_o  out  DATA_WIDTH  fetch read data
- data_req_i  in  1  data request
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  write enable
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_wdata_i  in  DATA_WIDTH  write data
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  DATA_WIDTH  data read data
- mem_req_o  out  1  request to memory
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid, in order, ≥1 cycle after grant
- mem_rdata_i  in  DATA_WIDTH  memory read data

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset state:
  - FSM in IDLE; ID FIFO empty; round-robin pointer favours data.
  - All outputs 0 while rst_ni is low.
- Requester rules: a requester holds req and its address/data stable until its gnt. A transaction is accepted in a cycle with req && gnt.
- FSM states:
  - IDLE:
    - One requester active: select it.
    - Both active: select the one not granted last (pointer); the pointer updates on every accepted transaction.
    - If mem_gnt_i is low in the selection cycle, go to LOCK_I or LOCK_D (matching the selected port).
  - LOCK_I / LOCK_D:
    - Selection is frozen; the other port is not granted even if it requests.
    - Return to IDLE on the cycle mem_gnt_i=1.
- Memory request path:
  - mem_req_o = selected req && !fifo_full.
  - mem_addr/we/be/wdata are driven combinationally from the selected port; for instr, we=0, be=all ones, wdata=0.
  - Port gnt = mem_gnt_i && mem_req_o && selected. This is combinational: zero-cycle grant when memory grants.
- Full FIFO: mem_req_o is forced low, even if a pop occurs in the same cycle (no push-through-pop). FSM state is unchanged.
- ID FIFO:
  - Push the port ID (0=instr, 1=data) on mem_req_o && mem_gnt_i.
  - Pop on mem_rvalid_i.
  - Push and pop in the same cycle keeps the count.
  - Count saturates correctly at 0 and MAX_OUTSTANDING; pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - instr_rvalid_o = mem_rvalid_i && !empty && head==0.
  - data_rvalid_o = mem_rvalid_i && !empty && head==1.
  - rdata outputs = mem_rdata_i on both ports (broadcast).
  - Writes also return rvalid (rdata don't-care).
- mem_rvalid_i with empty FIFO: ignored, no rvalid output, no pop.
- Reset mid-operation: outstanding IDs are discarded; responses arriving after reset release fall under the empty-FIFO rule.
- Latency: zero added cycles on request and response paths; throughput is one transaction per cycle.

Optional Feature:
- Macro: CORE_MEM_ARB_STATS_EN.
- When defined, three 32-bit output ports are added, all reset to 0 and wrapping modulo 2^32:
  - stat_instr_grants_o: accepted instr transactions.
  - stat_data_grants_o: accepted data transactions.
  - stat_conflicts_o: cycles with both req high and only one granted.
- When undefined: no ports, no counters; behaviour is otherwise identical.

Test Plan:
- Only instr_req=1 at addr 0x8000_0000, mem_gnt_i=1, rvalid 1 cycle later with rdata 0xDEAD_BEEF_0000_0001 -> instr_gnt_o same cycle; instr_rvalid_o next cycle with that rdata; data_rvalid_o stays 0.
- Both req every cycle, mem_gnt_i=1 -> grants alternate data,instr,data,instr starting with data after reset; responses are routed in the same order.
- Data write (be=0x0F, wdata=0x1122334455667788) while mem_gnt_i=0 for 3 cycles, instr_req rising in cycle 1 -> mem_* hold the data request all 3 cycles; instr not granted; data_gnt_o on cycle 4, then instr granted cycle 5.
- MAX_OUTSTANDING=2, mem_gnt_i=1, no rvalid -> 2 grants, then mem_req_o=0; one rvalid -> the next request is granted the cycle after the pop, not in the pop cycle.
- mem_rvalid_i=1 with empty FIFO -> no rvalid on either port.
- Assert rst_ni low with 2 outstanding -> all outputs 0; after release, late rvalids are dropped.
- With CORE_MEM_ARB_STATS_EN defined, 10 cycles of both req and mem_gnt_i=1 -> stat_instr_grants_o=5, stat_data_grants_o=5, stat_conflicts_o=10.
